// File: rtl/mod13_down_counter.sv
// Modulo-MODULUS down counter with a clamped parallel load and terminal count for cascading.
// Define BCD_OUT_EN to add the registered BCD outputs bcd_tens/bcd_ones (MODULUS <= 100 only).
module mod13_down_counter #(
    parameter int MODULUS = 13,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef BCD_OUT_EN
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
`endif
    output logic [WIDTH-1:0] qo,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_q;
    logic             load_bad;

    // The comparison is done at 32 bits so that MODULUS == 2**WIDTH never reports an illegal load.
    assign load_bad = load && (32'(load_val) >= MODULUS);

    // NOTE: every variable in an always_comb block gets a default value first, so that no latch is inferred.
    always_comb begin
        next_q = qo;
        if (load) begin
            next_q = load_bad ? TOP : load_val;
        end else if (en) begin
            next_q = (qo == '0) ? TOP : qo - WIDTH'(1);
        end
    end

    assign tc = en && (qo == '0);

    // NOTE: sequential state is assigned with <=, so that every flop samples its inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qo       <= TOP;
            qb       <= ~TOP;
            load_err <= 1'b0;
        end else begin
            qo       <= next_q;
            qb       <= ~next_q;
            load_err <= load_bad;
        end
    end

`ifdef BCD_OUT_EN
    localparam logic [3:0] TOP_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] TOP_ONES = 4'((MODULUS - 1) % 10);

    logic [3:0] tens_d;
    logic [3:0] ones_d;

    // The BCD is taken from next_q, so that it lands in the same cycle as qo.
    always_comb begin
        tens_d = 4'(32'(next_q) / 10);
        ones_d = 4'(32'(next_q) % 10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_tens <= TOP_TENS;
            bcd_ones <= TOP_ONES;
        end else begin
            bcd_tens <= tens_d;
            bcd_ones <= ones_d;
        end
    end
`endif

endmodule

// File: tb/tb_mod13_down_counter.sv
// Directed, table-driven bench for mod13_down_counter (MODULUS=13, WIDTH=4).
// Define BCD_OUT_EN as well to check the BCD outputs.
module tb_mod13_down_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] qo;
    logic [3:0] qb;
    logic       tc;
    logic       load_err;
`ifdef BCD_OUT_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mod13_down_counter #(.MODULUS(13), .WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .load_val (load_val),
`ifdef BCD_OUT_EN
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
`endif
        .qo       (qo),
        .qb       (qb),
        .tc       (tc),
        .load_err (load_err)
    );

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] lv;
        logic       exp_tc;   // tc during the cycle, before the edge
        logic [3:0] exp_q;    // qo after the edge
        logic       exp_err;  // load_err after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_q(input string name, input logic [3:0] exp_q, input logic exp_err);
        logic [3:0] exp_qb;
        exp_qb = ~exp_q;
        check({name, " qo"}, 32'(qo), 32'(exp_q));
        check({name, " qb"}, 32'(qb), 32'(exp_qb));
        check({name, " load_err"}, 32'(load_err), 32'(exp_err));
`ifdef BCD_OUT_EN
        check({name, " bcd_tens"}, 32'(bcd_tens), 32'(exp_q) / 10);
        check({name, " bcd_ones"}, 32'(bcd_ones), 32'(exp_q) % 10);
`endif
    endtask

    function automatic void add(input logic e, input logic l, input logic [3:0] lv,
                                input logic t, input logic [3:0] q, input logic err);
        vec_t v;
        v.en = e; v.load = l; v.lv = lv; v.exp_tc = t; v.exp_q = q; v.exp_err = err;
        vecs.push_back(v);
    endfunction

    // Inputs are driven 1 ns after a posedge, tc is sampled on the negedge and registers 1 ns after the next posedge.
    task automatic step(input vec_t v, input int idx);
        en       = v.en;
        load     = v.load;
        load_val = v.lv;
        @(negedge clk);
        check($sformatf("v%0d tc", idx), 32'(tc), 32'(v.exp_tc));
        @(posedge clk);
        #1;
        check_q($sformatf("v%0d", idx), v.exp_q, v.exp_err);
    endtask

    initial begin
        // Two full periods with en=1, run from the reset value 12: 12,11,...,0,12,...,0,12.
        for (int i = 0; i < 26; i++) begin
            int pre;
            int post;
            pre  = (12 - i + 26) % 13;
            post = (12 - (i + 1) + 26) % 13;
            add(1'b1, 1'b0, 4'd0, pre == 0, 4'(post), 1'b0);
        end
        // Count down from 12 to 5, hold for 3 cycles, then re-enable.
        add(1, 0, 0, 0, 11, 0); add(1, 0, 0, 0, 10, 0); add(1, 0, 0, 0, 9, 0);
        add(1, 0, 0, 0, 8, 0);  add(1, 0, 0, 0, 7, 0);  add(1, 0, 0, 0, 6, 0);
        add(1, 0, 0, 0, 5, 0);
        add(0, 0, 0, 0, 5, 0);  add(0, 0, 0, 0, 5, 0);  add(0, 0, 0, 0, 5, 0);
        add(1, 0, 0, 0, 4, 0);
        // A load beats en, then the count decrements from the loaded value.
        add(1, 1, 7, 0, 7, 0);
        add(1, 0, 0, 0, 6, 0);
        // Load 0, then load with en while qo==0: tc stays high and the load still wins.
        add(0, 1, 0, 0, 0, 0);
        add(1, 1, 3, 1, 3, 0);
        // Illegal loads are clamped to 12 and pulse load_err.
        add(0, 1, 14, 0, 12, 1);
        add(0, 0, 0, 0, 12, 0);
        add(1, 1, 13, 0, 12, 1);
        add(0, 1, 15, 0, 12, 1);
        add(1, 0, 0, 0, 11, 0);
        add(0, 1, 12, 0, 12, 0);
        // Wrap from 0 to 12 under en, then park at 3 for the mid-cycle reset.
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 12, 0);
        add(0, 1, 3, 0, 3, 0);

        rst_n = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        #2 rst_n = 1'b0;
        #1;
        check_q("reset", 4'd12, 1'b0);
        check("reset tc", 32'(tc), 32'd0);
        #4 rst_n = 1'b1;  // released at t=7, between edges

        foreach (vecs[i]) step(vecs[i], i);

        // Reset asserted mid-cycle at qo=3 with a load pending: qo goes to 12 at once and the load is lost.
        en = 1'b1; load = 1'b1; load_val = 4'd5;
        #2 rst_n = 1'b0;
        #1;
        check_q("midreset", 4'd12, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_q("reset held", 4'd12, 1'b0);
        en = 1'b0; load = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_q("release hold", 4'd12, 1'b0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check_q("release count", 4'd11, 1'b0);

        // A mid-cycle reset also clears a pending load_err pulse.
        en = 1'b0; load = 1'b1; load_val = 4'd15;
        @(posedge clk);
        #1;
        check_q("err pulse", 4'd12, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_q("err reset", 4'd12, 1'b0);
        load = 1'b0;
        #2 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
